// File: rtl/fp_mul_pkg.sv
// fp_mul_sched shared types.
// Operand, rounding-mode and flag definitions.
package fp_mul_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  typedef struct packed {
    logic nan;
    logic udrf;
    logic ovrf;
  } fp_flags_t;

  localparam logic [2:0] RMODE_MAX = 3'd4;

endpackage

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Round-robin arbiter for fp_mul_sched.
// Search starts at ptr and wraps; output is one-hot or zero.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);

  logic found;
  int   idx;

  // first requester at or after ptr, modulo NREQ
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one fp32 multiplier between NREQ requesters.
// Round-robin issue, tag pipeline routes results back.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x,
  input  logic [NREQ*32-1:0] req_y,
  input  logic [NREQ*3-1:0] req_rmode,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  output logic [2:0]        mul_rmode,
  input  logic [31:0]       mul_z,
  input  logic              mul_ovrf,
  input  logic              mul_udrf,
  input  logic              mul_nan,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_z,
  output logic [2:0]        rsp_flags,
  output logic              busy,
  output logic              err_rmode
);

  localparam int PW = $clog2(NREQ);
  localparam int NS = MUL_LAT + 1;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            accept;
  logic [2:0]      pick_rm;

  logic [PW-1:0]   ptr_q, ptr_d;
  fp32_t           mul_x_q, mul_x_d;
  fp32_t           mul_y_q, mul_y_d;
  logic [2:0]      mul_rm_q, mul_rm_d;
  logic            err_q, err_d;
  logic [NS-1:0]   tv_q, tv_d;
  logic [PW-1:0]   tid_q [NS];
  logic [PW-1:0]   tid_d [NS];
  logic [NREQ-1:0] rsp_v_q, rsp_v_d;
  fp32_t           rsp_z_q, rsp_z_d;
  fp_flags_t       rsp_f_q, rsp_f_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign req_ready = en ? gnt : '0;
  assign accept    = |req_ready;

  // binary index of the granted requester
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  // issue side: operand registers, pointer, rmode sanitising
  always_comb begin
    ptr_d    = ptr_q;
    mul_x_d  = mul_x_q;
    mul_y_d  = mul_y_q;
    mul_rm_d = mul_rm_q;
    err_d    = err_q;
    pick_rm  = req_rmode[3*int'(gidx) +: 3];
    if (accept) begin
      ptr_d   = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
      mul_x_d = req_x[32*int'(gidx) +: 32];
      mul_y_d = req_y[32*int'(gidx) +: 32];
      if (pick_rm > RMODE_MAX) begin
        mul_rm_d = RNE;
        err_d    = 1'b1;
      end else begin
        mul_rm_d = pick_rm;
      end
    end
  end

  // tag pipeline tracks each in-flight op's owner
  always_comb begin
    tv_d     = '0;
    tv_d[0]  = accept;
    tid_d[0] = gidx;
    for (int k = 1; k < NS; k++) begin
      tv_d[k]  = tv_q[k-1];
      tid_d[k] = tid_q[k-1];
    end
  end

  // capture result when the last tag stage is valid
  always_comb begin
    rsp_v_d = '0;
    rsp_z_d = rsp_z_q;
    rsp_f_d = rsp_f_q;
    if (tv_q[NS-1]) begin
      rsp_v_d[tid_q[NS-1]] = 1'b1;
      rsp_z_d      = mul_z;
      rsp_f_d.nan  = mul_nan;
      rsp_f_d.udrf = mul_udrf;
      rsp_f_d.ovrf = mul_ovrf;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      mul_x_q  <= '0;
      mul_y_q  <= '0;
      mul_rm_q <= '0;
      err_q    <= 1'b0;
      tv_q     <= '0;
      for (int k = 0; k < NS; k++) tid_q[k] <= '0;
      rsp_v_q  <= '0;
      rsp_z_q  <= '0;
      rsp_f_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mul_x_q  <= mul_x_d;
      mul_y_q  <= mul_y_d;
      mul_rm_q <= mul_rm_d;
      err_q    <= err_d;
      tv_q     <= tv_d;
      tid_q    <= tid_d;
      rsp_v_q  <= rsp_v_d;
      rsp_z_q  <= rsp_z_d;
      rsp_f_q  <= rsp_f_d;
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_rmode = mul_rm_q;
  assign rsp_valid = rsp_v_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_flags = rsp_f_q;
  assign err_rmode = err_q;
  assign busy      = (|tv_q) | (|rsp_v_q);

endmodule

// File: tb/tb_fp_mul_sched.sv
// Bench for fp_mul_sched.
// Stub multiplier plus transaction-level scoreboard.
module tb_fp_mul_sched;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_x = '0;
  logic [NREQ*32-1:0] req_y = '0;
  logic [NREQ*3-1:0] req_rmode = '0;
  logic [31:0]       mul_x, mul_y, mul_z;
  logic [2:0]        mul_rmode;
  logic              mul_ovrf, mul_udrf, mul_nan;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_z;
  logic [2:0]        rsp_flags;
  logic              busy, err_rmode;

  fp_mul_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
    .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
    .mul_z(mul_z), .mul_ovrf(mul_ovrf),
    .mul_udrf(mul_udrf), .mul_nan(mul_nan),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z),
    .rsp_flags(rsp_flags), .busy(busy),
    .err_rmode(err_rmode)
  );

  always #5 clk = ~clk;

  // stand-in multiplier: {nan,udrf,ovrf,z}
  function automatic logic [34:0] stub_mul(
    logic [31:0] x, logic [31:0] y, logic [2:0] r);
    logic [31:0] z;
    logic nan, udrf, ovrf;
    int e;
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    nan = (x[30:23] == 8'hFF && x[22:0] != 0) ||
          (y[30:23] == 8'hFF && y[22:0] != 0);
    ovrf = x[30:23] != 8'hFF && y[30:23] != 8'hFF && e >= 255;
    udrf = x[30:23] != 8'h00 && y[30:23] != 8'h00 && e <= 0;
    if (y == 32'h3F80_0000) z = x;
    else if (x == 32'h40B0_0000 && y == 32'hC010_0000)
      z = 32'hC146_0000;
    else z = x ^ {y[15:0], y[31:16]} ^ {29'd0, r};
    return {nan, udrf, ovrf, z};
  endfunction

  // MUL_LAT = 2 register stages
  logic [34:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= stub_mul(mul_x, mul_y, mul_rmode);
    s2 <= s1;
  end
  assign mul_z = s2[31:0];
  assign {mul_nan, mul_udrf, mul_ovrf} = s2[34:32];

  typedef struct {
    int          id;
    int          due;
    logic [31:0] z;
    logic [2:0]  f;
  } exp_t;

  exp_t        q[$];
  int          grants[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, mptr = 0, pulses = 0;
  logic        err_exp = 1'b0;
  logic [31:0] lx = '0, ly = '0;
  logic [2:0]  lrm = '0;
  int          last_id = -1;
  logic [31:0] last_z = '0;
  logic [2:0]  last_f = '0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    mptr = 0; err_exp = 1'b0;
    lx = '0; ly = '0; lrm = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_y", mul_y, 0);
    chk("rst_mul_rm", mul_rmode, 0);
    chk("rst_rsp_v", rsp_valid, 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_rsp_f", rsp_flags, 0);
    chk("rst_err", err_rmode, 0);
    chk("rst_busy", busy, 0);
  endtask

  // one clock: check grant, predict, advance, check outputs
  task automatic tick();
    logic [NREQ-1:0] er, oh;
    logic [2:0] rm;
    logic [34:0] s;
    logic pres;
    int g;
    #1;
    er = '0; g = -1;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    if (g >= 0) begin
      rm = req_rmode[3*g +: 3];
      if (rm > 3'd4) begin rm = 3'd0; err_exp = 1'b1; end
      lx = req_x[32*g +: 32];
      ly = req_y[32*g +: 32];
      lrm = rm;
      s = stub_mul(lx, ly, lrm);
      q.push_back('{id: g, due: cyc + MUL_LAT + 2,
                    z: s[31:0], f: s[34:32]});
      grants.push_back(g);
      mptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    pres = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      oh = '0; oh[q[0].id] = 1'b1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_z", rsp_z, q[0].z);
      chk("rsp_flags", rsp_flags, q[0].f);
      last_id = q[0].id; last_z = q[0].z; last_f = q[0].f;
      pulses++;
      void'(q.pop_front());
      pres = 1'b1;
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
    chk("busy", busy, (q.size() > 0) || pres);
    chk("mul_x", mul_x, lx);
    chk("mul_y", mul_y, ly);
    chk("mul_rmode", mul_rmode, lrm);
    chk("err_rmode", err_rmode, err_exp);
  endtask

  task automatic set_req(int i, logic [31:0] x,
                         logic [31:0] y, logic [2:0] r);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
    req_rmode[3*i +: 3] = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk_reset_vals();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
  endtask

  initial begin
    // power-on reset
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    model_reset();

    // single op from requester 1
    en = 1'b1;
    set_req(1, 32'h40B0_0000, 32'hC010_0000, 3'd0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("t1_id", last_id, 1);
    chk("t1_z", last_z, 32'hC146_0000);
    chk("t1_f", last_f, 0);

    // all four streaming, ptr from 0
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 32'h3F80_0000 + 32'h0080_0000 * (i == 0 ? 0 : 1)
                 + 32'h0040_0000 * (i >= 2 ? i - 1 : 0),
              32'h3F80_0000, 3'd0);
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0);
    set_req(1, 32'h4000_0000, 32'h3F80_0000, 3'd0);
    set_req(2, 32'h4040_0000, 32'h3F80_0000, 3'd0);
    set_req(3, 32'h4080_0000, 32'h3F80_0000, 3'd0);
    grants.delete();
    req_valid = 4'b1111;
    repeat (5) tick();
    req_valid = '0;
    chk("t2_g0", grants[0], 0);
    chk("t2_g1", grants[1], 1);
    chk("t2_g2", grants[2], 2);
    chk("t2_g3", grants[3], 3);
    chk("t2_g4", grants[4], 0);
    repeat (6) tick();
    chk("t2_last_z", last_z, 32'h3F80_0000);

    // en drop after 3 accepts
    pulses = 0;
    set_req(2, 32'h4040_0000, 32'h4000_0000, 3'd1);
    req_valid = 4'b0100;
    repeat (3) tick();
    en = 1'b0;
    repeat (8) tick();
    chk("t3_pulses", pulses, 3);
    chk("t3_busy", busy, 0);
    req_valid = '0;
    en = 1'b1;

    // illegal rmode forwarded as RNE, sticky flag
    set_req(0, 32'h4000_0000, 32'h4000_0000, 3'd6);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("t4_rm", mul_rmode, 0);
    chk("t4_err", err_rmode, 1);
    repeat (10) tick();
    chk("t4_err_hold", err_rmode, 1);

    // overflow flag routed to requester 3
    set_req(3, 32'h7F00_0000, 32'h7F00_0000, 3'd0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("t5_id", last_id, 3);
    chk("t5_f", last_f, 3'b001);

    // async reset with ops in flight
    set_req(1, 32'h4000_0000, 32'h3F80_0000, 3'd0);
    set_req(2, 32'h4040_0000, 32'h3F80_0000, 3'd0);
    req_valid = 4'b0110;
    repeat (2) tick();
    req_valid = '0;
    @(posedge clk);
    cyc++;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) tick();
    chk("t6_no_rsp", pulses, 0);
    grants.delete();
    req_valid = 4'b1111;
    tick();
    req_valid = '0;
    chk("t6_first", grants.size() > 0 ? grants[0] : -1, 0);
    repeat (5) tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) < 8);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom, $urandom,
                3'($urandom_range(0, 7)));
      tick();
    end
    en = 1'b0;
    req_valid = '0;
    repeat (6) tick();
    chk("drain_q", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
